// File: rtl/systolic_mult_array.sv
// systolic_mult_array: pipelined bit-level systolic multiplier with skewed operand
// entry, signed/unsigned mode, pass-through tag and valid/ready backpressure.
module systolic_mult_array #(
    parameter int WIDTH = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);
    localparam int PW  = 2 * WIDTH;
    localparam int LAT = 2 * WIDTH + 1;
    localparam int MD  = LAT - 1;

    logic                adv;
    logic [WIDTH-1:0]    ma_d, mb_d, ma, mb;
    logic                neg_d;
    logic [MD-1:0]       v, neg;
    logic [TAG_W-1:0]    tag [MD];
    logic [WIDTH-1:0]    ska, skb;
    logic [WIDTH-1:0]    a_in [WIDTH];
    logic [WIDTH-1:0]    b_in [WIDTH];
    logic [PW-1:0]       s_nx [WIDTH][WIDTH];
    logic [PW-1:0]       s_q  [WIDTH][WIDTH];
    logic [WIDTH-1:0]    a_q  [WIDTH-1];
    logic [WIDTH-2:0]    b_q  [WIDTH];
    logic                fix_v;
    logic [PW-1:0]       fix_p;
    logic [TAG_W-1:0]    fix_tag;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign busy     = |v || fix_v || out_valid;

    // Signed operands enter the array as magnitudes; the product sign travels alongside.
    always_comb begin
        ma_d  = '0;
        mb_d  = '0;
        neg_d = 1'b0;
        if (in_valid) begin
            ma_d  = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
            mb_d  = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
            neg_d = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        end
    end

    // Input register plus the valid/sign/tag side-band that shadows the array wavefront.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ma  <= '0;
            mb  <= '0;
            v   <= '0;
            neg <= '0;
            for (int i = 0; i < MD; i++) tag[i] <= '0;
        end else if (adv) begin
            ma     <= ma_d;
            mb     <= mb_d;
            v      <= {v[MD-2:0], in_valid};
            neg    <= {neg[MD-2:0], neg_d};
            tag[0] <= in_valid ? in_tag : '0;
            for (int i = 1; i < MD; i++) tag[i] <= tag[i-1];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_skew
        if (i == 0) begin : g_none
            assign ska[0] = ma[0];
            assign skb[0] = mb[0];
        end else begin : g_dly
            logic [i-1:0] da, db;
            // Bit i waits i cycles so it meets its partner bit at cell (r,c) on cycle r+c.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    da <= '0;
                    db <= '0;
                end else if (adv) begin
                    da[0] <= ma[i];
                    db[0] <= mb[i];
                    for (int j = 1; j < i; j++) begin
                        da[j] <= da[j-1];
                        db[j] <= db[j-1];
                    end
                end
            end
            assign ska[i] = da[i-1];
            assign skb[i] = db[i-1];
        end
    end

    // A bits flow down columns, B bits flow right along rows, column sums flow down
    // and the bottom row merges them left to right so the corner holds the product.
    for (genvar r = 0; r < WIDTH; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            logic [PW-1:0] s_in;
            if (r == 0) begin : g_top
                assign a_in[r][c] = ska[c];
                assign s_in       = '0;
            end else begin : g_mid
                assign a_in[r][c] = a_q[r-1][c];
                if (r == WIDTH - 1 && c > 0) begin : g_merge
                    assign s_in = s_q[r-1][c] + s_q[r][c-1];
                end else begin : g_down
                    assign s_in = s_q[r-1][c];
                end
            end
            if (c == 0) begin : g_left
                assign b_in[r][c] = skb[r];
            end else begin : g_right
                assign b_in[r][c] = b_q[r][c-1];
            end
            assign s_nx[r][c] = s_in + (PW'(a_in[r][c] & b_in[r][c]) << (r + c));
        end
    end

    // PE state: running sums and the forwarded operand bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++)
                for (int j = 0; j < WIDTH; j++) s_q[i][j] <= '0;
            for (int i = 0; i < WIDTH - 1; i++) a_q[i] <= '0;
            for (int i = 0; i < WIDTH; i++) b_q[i] <= '0;
        end else if (adv) begin
            for (int i = 0; i < WIDTH; i++)
                for (int j = 0; j < WIDTH; j++) s_q[i][j] <= s_nx[i][j];
            for (int i = 0; i < WIDTH - 1; i++) a_q[i] <= a_in[i];
            for (int i = 0; i < WIDTH; i++) b_q[i] <= b_in[i][WIDTH-2:0];
        end
    end

    // Sign restore stage followed by the output register held under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fix_v     <= 1'b0;
            fix_p     <= '0;
            fix_tag   <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            fix_v     <= v[MD-1];
            fix_p     <= neg[MD-1] ? -s_q[WIDTH-1][WIDTH-1] : s_q[WIDTH-1][WIDTH-1];
            fix_tag   <= tag[MD-1];
            out_valid <= fix_v;
            out_p     <= fix_p;
            out_tag   <= fix_tag;
        end
    end
endmodule

// File: tb/tb_systolic_mult_array.sv
// tb_systolic_mult_array: directed and random stimulus against a latency/arithmetic reference model.
module tb_systolic_mult_array;
    localparam int W   = 4;
    localparam int TW  = 4;
    localparam int PW  = 2 * W;
    localparam int LAT = 2 * W + 1;

    typedef struct packed {
        logic          v;
        logic [PW-1:0] p;
        logic [TW-1:0] t;
    } slot_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_signed = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_ready, out_valid, busy;
    logic [PW-1:0] out_p;
    logic [TW-1:0] out_tag;

    int            checks = 0;
    int            errors = 0;
    int            nacc = 0;
    slot_t         m [LAT+1];
    logic [PW-1:0] got [$];
    logic [PW-1:0] ex [$];

    systolic_mult_array #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return PW'(x * y);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: drive, check against the model, clock, update the model.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [TW-1:0] t, input logic ordy, input logic rn);
        logic adv, anyv;
        in_valid = v; in_a = a; in_b = b; in_signed = s; in_tag = t;
        out_ready = ordy; rst_n = rn;
        #1;
        adv = !m[LAT].v || ordy;
        anyv = 1'b0;
        for (int i = 0; i <= LAT; i++) anyv |= m[i].v;
        chk("in_ready", in_ready, adv);
        chk("out_valid", out_valid, m[LAT].v);
        chk("busy", busy, anyv);
        if (m[LAT].v) begin
            chk("out_p", out_p, m[LAT].p);
            chk("out_tag", out_tag, m[LAT].t);
        end
        if (rn && out_valid && out_ready) got.push_back(out_p);
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i <= LAT; i++) m[i] = '0;
        end else if (adv) begin
            for (int i = LAT; i > 0; i--) m[i] = m[i-1];
            m[0] = '{v: v, p: v ? prod(a, b, s) : '0, t: t};
            if (v) nacc++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        for (int i = 0; i <= LAT; i++) m[i] = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_p", out_p, '0);
        chk("rst_out_tag", out_tag, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 20; i++) begin
            idle(1);
            chk("idle_out_p", out_p, '0);
        end

        got.delete();
        cycle(1'b1, 4'hF, 4'hF, 1'b0, 4'h3, 1'b1, 1'b1);
        idle(LAT + 3);
        chk("u15x15_count", got.size(), 1);
        if (got.size() > 0) chk("u15x15_p", got[0], 8'hE1);

        got.delete();
        cycle(1'b1, 4'h8, 4'h7, 1'b1, 4'h1, 1'b1, 1'b1);
        cycle(1'b1, 4'h8, 4'h8, 1'b1, 4'h2, 1'b1, 1'b1);
        cycle(1'b1, 4'hF, 4'hF, 1'b1, 4'h3, 1'b1, 1'b1);
        cycle(1'b1, 4'h7, 4'hF, 1'b1, 4'h4, 1'b1, 1'b1);
        idle(LAT + 3);
        chk("sgn_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("sgn_m8x7", got[0], 8'hC8);
            chk("sgn_m8xm8", got[1], 8'h40);
            chk("sgn_m1xm1", got[2], 8'h01);
            chk("sgn_7xm1", got[3], 8'hF9);
        end

        got.delete();
        ex.delete();
        for (int i = 0; i < 9; i++) begin
            logic [W-1:0] a, b;
            logic s;
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            ex.push_back(prod(a, b, s));
            cycle(1'b1, a, b, s, TW'(i), 1'b1, 1'b1);
        end
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, W'($urandom), W'($urandom), 1'b0, 4'hE, 1'b0, 1'b1);
        idle(LAT + 3);
        chk("fill_count", got.size(), 9);
        if (got.size() == 9)
            for (int i = 0; i < 9; i++) chk("fill_order", got[i], ex[i]);

        got.delete();
        for (int i = 0; i < 5; i++)
            cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 4'hA, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 4'h2, 4'h3, 1'b0, 4'h5, 1'b1, 1'b1);
        idle(LAT + 3);
        chk("rstmid_count", got.size(), 1);
        if (got.size() > 0) chk("rstmid_p", got[0], 8'h06);

        got.delete();
        nacc = 0;
        for (int n = 0; n < 6000 && nacc < 1000; n++)
            cycle($urandom_range(0, 99) < 75, W'($urandom), W'($urandom), 1'($urandom),
                  TW'($urandom), $urandom_range(0, 99) >= 30, 1'b1);
        chk("rand_beats", nacc, 1000);
        idle(LAT + 3);
        chk("rand_drain", got.size(), nacc);
        chk("rand_idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
